ltssm_timer_bank: RTL and testbench

//  Bank of NUM_CH independent programmable timeout timers for the PCIe LTSSM
//  (Detect.Quiet 12 ms, Polling 24/48 ms, Recovery/Config 2 ms, etc.). Each

---
 rtl/ltssm_timer_bank.sv | 151 +++++++++++++++
 tb/tb_ltssm_timer_bank.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ltssm_timer_bank.sv
// Bank of independent programmable timeout timers for LTSSM state timing.
// Optional per-channel tick prescaler enabled by defining LTSSM_TIMER_PRESCALE_EN.
module ltssm_timer_bank #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NUM_CH-1:0]            start_i,
    input  logic [NUM_CH-1:0]            stop_i,
    input  logic [NUM_CH-1:0]            periodic_i,
    input  logic [NUM_CH*CNT_W-1:0]      timeout_i,
    input  logic [NUM_CH*PRESCALE_W-1:0] prescale_i,
    input  logic [NUM_CH-1:0]            irq_clr_i,
    output logic [NUM_CH-1:0]            busy_o,
    output logic [NUM_CH-1:0]            expired_o,
    output logic [NUM_CH-1:0]            irq_o,
    output logic                         irq_any_o
);

    localparam int unsigned CMP_W = CNT_W + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

`ifndef LTSSM_TIMER_PRESCALE_EN
    logic unused_prescale;
    assign unused_prescale = ^prescale_i;
`endif

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        state_e             state_q, state_d;
        logic [CNT_W-1:0]   cnt_q, cnt_d;
        logic [CNT_W-1:0]   tmo_q, tmo_d;
        logic               mode_q, mode_d;
        logic               expired_q, expired_d;
        logic               irq_q, irq_d;
        logic               load_c;
        logic               tick_c;
        logic               hit_c;
        logic [CMP_W-1:0]   cnt_inc_c;

        // Stop always beats a simultaneous start.
        assign load_c = start_i[ch] & ~stop_i[ch];

`ifdef LTSSM_TIMER_PRESCALE_EN
        logic [PRESCALE_W-1:0] psc_q, psc_d;
        logic [PRESCALE_W-1:0] psc_cnt_q, psc_cnt_d;

        assign tick_c = (psc_cnt_q == psc_q);

        always_comb begin
            psc_d     = psc_q;
            psc_cnt_d = psc_cnt_q;
            if (load_c) begin
                psc_d     = prescale_i[ch*PRESCALE_W +: PRESCALE_W];
                psc_cnt_d = '0;
            end else if (state_q == ST_RUN) begin
                psc_cnt_d = tick_c ? '0 : psc_cnt_q + PRESCALE_W'(1);
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                psc_q     <= '0;
                psc_cnt_q <= '0;
            end else begin
                psc_q     <= psc_d;
                psc_cnt_q <= psc_cnt_d;
            end
        end
`else
        assign tick_c = 1'b1;
`endif

        // Widened compare so a timeout of all-ones never wraps; timeout 0 acts as 1.
        assign cnt_inc_c = {1'b0, cnt_q} + CMP_W'(1);
        assign hit_c     = tick_c && (cnt_inc_c >= {1'b0, tmo_q});

        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            tmo_d     = tmo_q;
            mode_d    = mode_q;
            expired_d = 1'b0;
            irq_d     = irq_q;

            if (irq_clr_i[ch]) begin
                irq_d = 1'b0;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (load_c) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        tmo_d   = timeout_i[ch*CNT_W +: CNT_W];
                        mode_d  = periodic_i[ch];
                    end
                end
                ST_RUN: begin
                    if (stop_i[ch]) begin
                        state_d = ST_IDLE;
                    end else if (start_i[ch]) begin
                        cnt_d  = '0;
                        tmo_d  = timeout_i[ch*CNT_W +: CNT_W];
                        mode_d = periodic_i[ch];
                    end else if (hit_c) begin
                        expired_d = 1'b1;
                        irq_d     = 1'b1;
                        cnt_d     = '0;
                        if (!mode_q) begin
                            state_d = ST_IDLE;
                        end
                    end else if (tick_c) begin
                        cnt_d = cnt_inc_c[CNT_W-1:0];
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q   <= ST_IDLE;
                cnt_q     <= '0;
                tmo_q     <= '0;
                mode_q    <= 1'b0;
                expired_q <= 1'b0;
                irq_q     <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                tmo_q     <= tmo_d;
                mode_q    <= mode_d;
                expired_q <= expired_d;
                irq_q     <= irq_d;
            end
        end

        assign busy_o[ch]    = (state_q == ST_RUN);
        assign expired_o[ch] = expired_q;
        assign irq_o[ch]     = irq_q;
    end

    assign irq_any_o = |irq_o;

endmodule

// File: tb/tb_ltssm_timer_bank.sv
// Directed self-checking bench for ltssm_timer_bank; clk N = N edges after the start edge.
module tb_ltssm_timer_bank;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned PSC_W  = 8;

    logic                    clk_i;
    logic                    rst_ni;
    logic [NUM_CH-1:0]       start_i;
    logic [NUM_CH-1:0]       stop_i;
    logic [NUM_CH-1:0]       periodic_i;
    logic [NUM_CH*CNT_W-1:0] timeout_i;
    logic [NUM_CH*PSC_W-1:0] prescale_i;
    logic [NUM_CH-1:0]       irq_clr_i;
    logic [NUM_CH-1:0]       busy_o;
    logic [NUM_CH-1:0]       expired_o;
    logic [NUM_CH-1:0]       irq_o;
    logic                    irq_any_o;

    int n_checks = 0;
    int n_fail   = 0;

    ltssm_timer_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESCALE_W(PSC_W)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (start_i),
        .stop_i     (stop_i),
        .periodic_i (periodic_i),
        .timeout_i  (timeout_i),
        .prescale_i (prescale_i),
        .irq_clr_i  (irq_clr_i),
        .busy_o     (busy_o),
        .expired_o  (expired_o),
        .irq_o      (irq_o),
        .irq_any_o  (irq_any_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic cfg_ch(input int ch, input int tmo, input int psc, input logic per);
        timeout_i[ch*CNT_W +: CNT_W] = CNT_W'(tmo);
        prescale_i[ch*PSC_W +: PSC_W] = PSC_W'(psc);
        periodic_i[ch] = per;
    endtask

    // Pulse start for the masked channels; returns at clk 0.
    task automatic go(input logic [NUM_CH-1:0] mask);
        start_i = mask;
        cyc(1);
        start_i = '0;
    endtask

    task automatic clr_irq(input logic [NUM_CH-1:0] mask);
        irq_clr_i = mask;
        cyc(1);
        irq_clr_i = '0;
    endtask

    initial begin
        int exp_clk;
        rst_ni     = 1'b0;
        start_i    = '0;
        stop_i     = '0;
        periodic_i = '0;
        timeout_i  = '0;
        prescale_i = '0;
        irq_clr_i  = '0;
        #2;
        check_eq("rst_busy", 32'(busy_o), 32'h0);
        check_eq("rst_expired", 32'(expired_o), 32'h0);
        check_eq("rst_irq", 32'(irq_o), 32'h0);
        check_eq("rst_irq_any", 32'(irq_any_o), 32'h0);
        #20;
        @(negedge clk_i);
        rst_ni = 1'b1;
        cyc(1);

        // ch0 one-shot, timeout 5
        cfg_ch(0, 5, 0, 1'b0);
        go(4'b0001);
        check_eq("t1_busy_c0", 32'(busy_o[0]), 32'h1);
        cyc(4);
        check_eq("t1_exp_c4", 32'(expired_o[0]), 32'h0);
        cyc(1);
        check_eq("t1_exp_c5", 32'(expired_o[0]), 32'h1);
        check_eq("t1_irq_c5", 32'(irq_o[0]), 32'h1);
        check_eq("t1_busy_c5", 32'(busy_o[0]), 32'h0);
        check_eq("t1_any_c5", 32'(irq_any_o), 32'h1);
        cyc(1);
        check_eq("t1_exp_c6", 32'(expired_o[0]), 32'h0);
        check_eq("t1_irq_hold", 32'(irq_o[0]), 32'h1);
        clr_irq(4'b0001);
        check_eq("t1_irq_clr", 32'(irq_o[0]), 32'h0);
        check_eq("t1_any_clr", 32'(irq_any_o), 32'h0);

        // ch1 periodic, timeout 3, stop sampled at clk 7
        cfg_ch(1, 3, 0, 1'b1);
        go(4'b0010);
        cyc(2);
        check_eq("t2_exp_c2", 32'(expired_o[1]), 32'h0);
        cyc(1);
        check_eq("t2_exp_c3", 32'(expired_o[1]), 32'h1);
        cyc(1);
        check_eq("t2_exp_c4", 32'(expired_o[1]), 32'h0);
        cyc(2);
        check_eq("t2_exp_c6", 32'(expired_o[1]), 32'h1);
        check_eq("t2_busy_c6", 32'(busy_o[1]), 32'h1);
        stop_i[1] = 1'b1;
        cyc(1);
        stop_i = '0;
        check_eq("t2_busy_c7", 32'(busy_o[1]), 32'h0);
        cyc(2);
        check_eq("t2_exp_c9", 32'(expired_o[1]), 32'h0);
        clr_irq(4'b0010);

        // ch2 timeout 10, restart at clk 6 -> expiry at clk 16
        cfg_ch(2, 10, 0, 1'b0);
        go(4'b0100);
        cyc(5);
        start_i[2] = 1'b1;
        cyc(1);
        start_i = '0;
        for (int k = 1; k <= 10; k++) begin
            cyc(1);
            check_eq($sformatf("t3_restart_c%0d", k + 6), 32'(expired_o[2]), 32'(k == 10));
        end
        cyc(1);
        check_eq("t3_busy_end", 32'(busy_o[2]), 32'h0);
        // timeout 0 behaves as 1
        cfg_ch(2, 0, 0, 1'b0);
        go(4'b0100);
        cyc(1);
        check_eq("t3_tmo0_c1", 32'(expired_o[2]), 32'h1);
        clr_irq(4'b0100);
        check_eq("t3_irq_clr", 32'(irq_o), 32'h0);

        // expiry with simultaneous irq_clr: set wins
        cfg_ch(0, 2, 0, 1'b0);
        go(4'b0001);
        cyc(1);
        irq_clr_i[0] = 1'b1;
        cyc(1);
        irq_clr_i = '0;
        check_eq("t4_setwins_exp", 32'(expired_o[0]), 32'h1);
        check_eq("t4_setwins_irq", 32'(irq_o[0]), 32'h1);
        clr_irq(4'b0001);
        // stop and start together: stays idle
        start_i[0] = 1'b1;
        stop_i[0]  = 1'b1;
        cyc(1);
        start_i = '0;
        stop_i  = '0;
        check_eq("t4_ss_busy", 32'(busy_o[0]), 32'h0);
        cyc(2);
        check_eq("t4_ss_noexp", 32'(expired_o[0]), 32'h0);
        // stop on expiry edge suppresses pulse
        cfg_ch(0, 3, 0, 1'b0);
        go(4'b0001);
        cyc(2);
        stop_i[0] = 1'b1;
        cyc(1);
        stop_i = '0;
        check_eq("t4_stopexp_exp", 32'(expired_o[0]), 32'h0);
        check_eq("t4_stopexp_busy", 32'(busy_o[0]), 32'h0);
        check_eq("t4_stopexp_irq", 32'(irq_o[0]), 32'h0);

        // four channels together, then async reset at clk 5
        cfg_ch(0, 2, 0, 1'b0);
        cfg_ch(1, 4, 0, 1'b0);
        cfg_ch(2, 6, 0, 1'b0);
        cfg_ch(3, 8, 0, 1'b0);
        go(4'b1111);
        check_eq("t5_busy_c0", 32'(busy_o), 32'hF);
        cyc(1);
        check_eq("t5_any_c1", 32'(irq_any_o), 32'h0);
        cyc(1);
        check_eq("t5_exp_c2", 32'(expired_o), 32'h1);
        check_eq("t5_any_c2", 32'(irq_any_o), 32'h1);
        check_eq("t5_busy_c2", 32'(busy_o), 32'hE);
        cyc(1);
        check_eq("t5_exp_c3", 32'(expired_o), 32'h0);
        cyc(1);
        check_eq("t5_exp_c4", 32'(expired_o), 32'h2);
        check_eq("t5_irq_c4", 32'(irq_o), 32'h3);
        cyc(1);
        check_eq("t5_exp_c5", 32'(expired_o), 32'h0);
        rst_ni = 1'b0;
        #1;
        check_eq("t5_rst_busy", 32'(busy_o), 32'h0);
        check_eq("t5_rst_irq", 32'(irq_o), 32'h0);
        check_eq("t5_rst_any", 32'(irq_any_o), 32'h0);
        check_eq("t5_rst_exp", 32'(expired_o), 32'h0);
        cyc(2);
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cyc(1);
            check_eq($sformatf("t5_post_rst_%0d", k), 32'({expired_o, irq_o, busy_o}), 32'h0);
        end

        // ch3 timeout 4, prescale 2
`ifdef LTSSM_TIMER_PRESCALE_EN
        exp_clk = 12;
`else
        exp_clk = 4;
`endif
        cfg_ch(3, 4, 2, 1'b0);
        go(4'b1000);
        for (int k = 1; k <= 13; k++) begin
            cyc(1);
            check_eq($sformatf("t6_psc_c%0d", k), 32'(expired_o[3]), 32'(k == exp_clk));
        end
        check_eq("t6_irq", 32'(irq_o), 32'h8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
